// File: rtl/avalon_master_cmd_splitter_pkg.sv
// Shared types and constants for the Avalon master command splitter.
// State encoding, AVMF-style log2 helper, default word geometry.
package avalon_master_cmd_splitter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    FIN   = 2'd3
  } state_e;

  // Ceiling log2; exact for the power-of-two word sizes the bridge uses.
  function automatic integer log2(input integer value);
    integer r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  localparam int WORD_BYTES     = 4;
  localparam int ADDRMASK_WIDTH = log2(WORD_BYTES);

endpackage

// File: rtl/avalon_burst_len_calc.sv
// Combinational burst length: min(remaining, MAX_BURST), further limited to the
// words left before the next BOUNDARY_BYTES boundary when AVMCS_BOUNDARY_SPLIT_EN is defined.
module avalon_burst_len_calc #(
  parameter int ADDR_W         = 32,
  parameter int SIZE_W         = 24,
  parameter int MAX_BURST      = 256,
  parameter int BOUNDARY_BYTES = 4096,
  parameter int ADDR_LSB       = 2
) (
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [SIZE_W-1:0] remaining,
  output logic [8:0]        len
);

`ifdef AVMCS_BOUNDARY_SPLIT_EN
  localparam bit BOUNDARY_EN = 1'b1;
`else
  localparam bit BOUNDARY_EN = 1'b0;
`endif

  logic [8:0]        cap;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] words_to_boundary;

  always_comb begin
    cap               = (remaining > SIZE_W'(MAX_BURST)) ? 9'(MAX_BURST) : remaining[8:0];
    offset            = cur_addr & ADDR_W'(BOUNDARY_BYTES - 1);
    words_to_boundary = (ADDR_W'(BOUNDARY_BYTES) - offset) >> ADDR_LSB;
    len               = cap;
    if (BOUNDARY_EN && (words_to_boundary < ADDR_W'(cap))) len = words_to_boundary[8:0];
  end

endmodule

// File: rtl/avalon_master_cmd_splitter.sv
// Splits one DMA request into Avalon bursts on the bridge user_* command handshake.
// Accept->enable 2 cycles; one burst outstanding, enable held until user_done (optional AVMCS_BOUNDARY_SPLIT_EN).
module avalon_master_cmd_splitter
  import avalon_master_cmd_splitter_pkg::*;
#(
  parameter int C_AVM_ADDR_WIDTH = 32,
  parameter int C_AVM_DATA_WIDTH = WORD_BYTES * 8,
  parameter int SIZE_WIDTH       = 24,
  parameter int MAX_BURST        = 256,
  parameter int BOUNDARY_BYTES   = 4096
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [C_AVM_ADDR_WIDTH-1:0] req_addr,
  input  logic [SIZE_WIDTH-1:0]       req_size,
  output logic                        req_done,
  output logic                        busy,
  output logic [C_AVM_ADDR_WIDTH-1:0] user_addr,
  output logic                        user_read_enable,
  output logic                        user_write_enable,
  output logic [8:0]                  user_word_size,
  input  logic                        user_done
);

  localparam int BYTES_PER_WORD = C_AVM_DATA_WIDTH / 8;
  localparam int ADDR_LSB       = log2(BYTES_PER_WORD);
  localparam logic [C_AVM_ADDR_WIDTH-1:0] ADDR_MASK = ~C_AVM_ADDR_WIDTH'(BYTES_PER_WORD - 1);

  state_e                      state_q, state_d;
  logic                        write_q, write_d;
  logic [C_AVM_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [SIZE_WIDTH-1:0]       remaining_q, remaining_d;
  logic [C_AVM_ADDR_WIDTH-1:0] user_addr_q, user_addr_d;
  logic [8:0]                  word_size_q, word_size_d;
  logic                        rd_en_q, rd_en_d;
  logic                        wr_en_q, wr_en_d;
  logic                        req_ready_q, req_ready_d;
  logic                        req_done_q, req_done_d;
  logic                        busy_q, busy_d;
  logic [8:0]                  burst_len;

  avalon_burst_len_calc #(
    .ADDR_W        (C_AVM_ADDR_WIDTH),
    .SIZE_W        (SIZE_WIDTH),
    .MAX_BURST     (MAX_BURST),
    .BOUNDARY_BYTES(BOUNDARY_BYTES),
    .ADDR_LSB      (ADDR_LSB)
  ) u_len_calc (
    .cur_addr (cur_addr_q),
    .remaining(remaining_q),
    .len      (burst_len)
  );

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    user_addr_d = user_addr_q;
    word_size_d = word_size_q;
    rd_en_d     = rd_en_q;
    wr_en_d     = wr_en_q;
    req_ready_d = req_ready_q;
    req_done_d  = 1'b0;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          cur_addr_d  = req_addr & ADDR_MASK;
          remaining_d = req_size;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = (req_size == '0) ? FIN : CALC;
        end
      end
      CALC: begin
        user_addr_d = cur_addr_q;
        word_size_d = burst_len;
        rd_en_d     = ~write_q;
        wr_en_d     = write_q;
        state_d     = ISSUE;
      end
      ISSUE: begin
        // Dropping the enable here guarantees the low gap the bridge needs to
        // avoid restarting the burst it just finished.
        if (user_done) begin
          rd_en_d     = 1'b0;
          wr_en_d     = 1'b0;
          cur_addr_d  = cur_addr_q + (C_AVM_ADDR_WIDTH'(word_size_q) << ADDR_LSB);
          remaining_d = remaining_q - SIZE_WIDTH'(word_size_q);
          state_d     = (remaining_d != '0) ? CALC : FIN;
        end
      end
      FIN: begin
        req_done_d  = 1'b1;
        busy_d      = 1'b0;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      user_addr_q <= '0;
      word_size_q <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      req_ready_q <= 1'b1;
      req_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      user_addr_q <= user_addr_d;
      word_size_q <= word_size_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      req_ready_q <= req_ready_d;
      req_done_q  <= req_done_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready         = req_ready_q;
  assign req_done          = req_done_q;
  assign busy              = busy_q;
  assign user_addr         = user_addr_q;
  assign user_read_enable  = rd_en_q;
  assign user_write_enable = wr_en_q;
  assign user_word_size    = word_size_q;

endmodule

// File: tb/tb_avalon_master_cmd_splitter.sv
// Bench for avalon_master_cmd_splitter: directed plus random requests, the bench
// acts as the bridge and compares every burst against an arithmetic burst-list model.
module tb_avalon_master_cmd_splitter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = 24;
  localparam int MB    = 256;
  localparam int BB    = 4096;
  localparam int BYTES = DW / 8;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [SW-1:0] req_size;
  logic          req_done;
  logic          busy;
  logic [AW-1:0] user_addr;
  logic          user_read_enable;
  logic          user_write_enable;
  logic [8:0]    user_word_size;
  logic          user_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr[$];
  int          exp_len[$];

  always #5 ACLK = ~ACLK;

  avalon_master_cmd_splitter #(
    .C_AVM_ADDR_WIDTH(AW),
    .C_AVM_DATA_WIDTH(DW),
    .SIZE_WIDTH      (SW),
    .MAX_BURST       (MB),
    .BOUNDARY_BYTES  (BB)
  ) dut (
    .ACLK             (ACLK),
    .ARESETN          (ARESETN),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_size         (req_size),
    .req_done         (req_done),
    .busy             (busy),
    .user_addr        (user_addr),
    .user_read_enable (user_read_enable),
    .user_write_enable(user_write_enable),
    .user_word_size   (user_word_size),
    .user_done        (user_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected burst list straight from the splitting rules.
  function automatic void build_model(input logic [31:0] addr, input int size);
    logic [31:0] a;
    int          r;
    int          l;
    exp_addr.delete();
    exp_len.delete();
    a = addr & ~32'(BYTES - 1);
    r = size;
    while (r > 0) begin
      l = (r > MB) ? MB : r;
`ifdef AVMCS_BOUNDARY_SPLIT_EN
      begin
        int wtb;
        wtb = (BB - int'(a % BB)) / BYTES;
        if (wtb < l) l = wtb;
      end
`endif
      exp_addr.push_back(a);
      exp_len.push_back(l);
      a = a + 32'(l * BYTES);
      r = r - l;
    end
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_done"}, req_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_enables"}, {user_read_enable, user_write_enable}, 0);
    check({tag, "_user_addr"}, user_addr, 0);
    check({tag, "_word_size"}, user_word_size, 0);
  endtask

  // Issues one request and plays the bridge; rst_at != 0 pulses reset when that burst starts.
  task automatic run_req(input bit wr, input logic [31:0] addr, input int size,
                         input int delay, input int rst_at);
    int          cyc;
    int          nb;
    int          hold;
    int          n_exp;
    bit          en_prev;
    bit          done_drv;
    bit          finished;
    logic [31:0] cur_a;
    logic [8:0]  cur_l;
    build_model(addr, size);
    n_exp = exp_addr.size();
    @(negedge ACLK);
    check("ready_before_accept", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_size  = SW'(size);
    @(negedge ACLK);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_size  = SW'($urandom);
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", req_ready, 0);
    cyc = 1; nb = 0; hold = 0; en_prev = 0; done_drv = 0; finished = 0;
    cur_a = '0; cur_l = '0;
    while (!finished && cyc < 20000) begin
      @(negedge ACLK);
      cyc++;
      user_done = 1'b0;
      if (done_drv) begin
        check("enable_low_after_done", {user_read_enable, user_write_enable}, 0);
        done_drv = 0;
      end else if (user_read_enable || user_write_enable) begin
        if (!en_prev) begin
          if (nb == 0) check("accept_to_enable_latency", cyc, 2);
          check("enable_select", {user_read_enable, user_write_enable}, wr ? 2'b01 : 2'b10);
          if (nb >= n_exp) begin
            check("extra_burst_index", nb, n_exp - 1);
          end else begin
            check("burst_addr", user_addr, exp_addr.pop_front());
            check("burst_len", user_word_size, exp_len.pop_front());
          end
          cur_a = user_addr;
          cur_l = user_word_size;
          hold  = 0;
          nb++;
          if (rst_at != 0 && nb == rst_at) begin
            #2 ARESETN = 1'b0;
            #1 check_reset_values("async_reset");
            user_done = 1'b0;
            req_valid = 1'b0;
            repeat (2) @(negedge ACLK);
            check_reset_values("held_reset");
            ARESETN = 1'b1;
            return;
          end
        end else begin
          hold++;
          check("burst_hold_stable", {user_addr, user_word_size, user_read_enable, user_write_enable},
                {cur_a, cur_l, ~wr, wr});
        end
        if (hold == delay) begin
          user_done = 1'b1;
          done_drv  = 1;
        end
      end else if (busy && $urandom_range(0, 3) == 0) begin
        user_done = 1'b1;  // stray pulse outside ISSUE must be ignored
      end
      en_prev = user_read_enable || user_write_enable;
      if (req_done) begin
        check("busy_low_with_done", busy, 0);
        check("burst_count", nb, n_exp);
        if (size == 0) check("zero_size_done_latency", cyc, 2);
        finished = 1;
      end else begin
        check("busy_during_request", busy, 1);
      end
      req_valid = finished ? 1'b0 : 1'($urandom_range(0, 1));
    end
    req_valid = 1'b0;
    user_done = 1'b0;
    if (!finished) check("req_done_timeout_cycles", cyc, 64'hFFFF_FFFF);
    @(negedge ACLK);
    check("done_single_pulse", req_done, 0);
    check("ready_after_done", req_ready, 1);
  endtask

  initial begin
    ARESETN   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    user_done = 1'b0;
    repeat (3) @(negedge ACLK);
    check_reset_values("reset");
    ARESETN = 1'b1;

    run_req(1'b0, 32'h0000_1000, 600, 2, 0);
    run_req(1'b1, 32'h0000_0FF0, 10, 1, 0);
    run_req(1'b0, 32'h0000_0123, 0, 0, 0);
    run_req(1'b1, 32'h0000_2002, 300, 50, 0);
    run_req(1'b0, 32'h0000_1000, 600, 3, 2);
    run_req(1'b1, 32'h0000_0040, 5, 0, 0);
    run_req(1'b0, 32'hFFFF_FF00, 128, 1, 0);
    run_req(1'b1, 32'hFFFF_FC00, 600, 0, 0);

    for (int i = 0; i < 14; i++) begin
      run_req(1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 700)),
              int'($urandom_range(0, 4)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
